// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch, stall/redirect handling and
// a one-entry hold buffer that catches imem data returning while decode is stalled.
module fetch_stage #(
   parameter int unsigned ADDR_W   = 12,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_q,
   output logic [31:0]       instr_fd,
   output logic [31:0]       pc_fd,
   output logic              valid_fd
);

   logic [31:0] pc;
   logic [31:0] req_pc;
   logic        req_valid;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic        hold_valid;

   logic [31:0] cand_instr;
   logic [31:0] cand_pc;
   logic        cand_valid;
   logic [31:0] req_pc_inc;

   assign imem_addr  = pc[ADDR_W-1:0];
   assign req_pc_inc = req_pc + 32'd1;

   // A held instruction is older than anything on imem_q, so it always goes first.
   always_comb begin
      cand_instr = '0;
      cand_pc    = '0;
      cand_valid = 1'b0;
      if (hold_valid) begin
         cand_instr = hold_instr;
         cand_pc    = hold_pc;
         cand_valid = 1'b1;
      end else if (req_valid) begin
         cand_instr = imem_q;
         cand_pc    = req_pc_inc;
         cand_valid = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc         <= RESET_PC;
         req_pc     <= '0;
         req_valid  <= 1'b0;
         hold_instr <= '0;
         hold_pc    <= '0;
         hold_valid <= 1'b0;
         instr_fd   <= '0;
         pc_fd      <= '0;
         valid_fd   <= 1'b0;
      end else if (redirect) begin
         pc         <= redirect_pc;
         req_valid  <= 1'b0;
         hold_valid <= 1'b0;
         instr_fd   <= '0;
         pc_fd      <= '0;
         valid_fd   <= 1'b0;
      end else if (stall) begin
         // The address shown during a stall is re-issued on release, so this
         // cycle's access is dropped rather than tracked.
         req_valid <= 1'b0;
         if (!hold_valid && req_valid) begin
            hold_instr <= imem_q;
            hold_pc    <= req_pc_inc;
            hold_valid <= 1'b1;
         end
      end else begin
         instr_fd   <= cand_instr;
         pc_fd      <= cand_pc;
         valid_fd   <= cand_valid;
         hold_valid <= 1'b0;
         req_pc     <= pc;
         req_valid  <= 1'b1;
         pc         <= pc + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for streaming, stall and redirect,
// then hand-written sequences for long stalls, redirect-over-stall, PC wrap and reset.
module tb_fetch_stage;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [11:0] imem_addr;
   logic [31:0] imem_q;
   logic [31:0] instr_fd;
   logic [31:0] pc_fd;
   logic        valid_fd;

   int tests_run;
   int tests_failed;

   fetch_stage #(.ADDR_W(12), .RESET_PC(32'd0)) dut (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_addr  (imem_addr),
      .imem_q     (imem_q),
      .instr_fd   (instr_fd),
      .pc_fd      (pc_fd),
      .valid_fd   (valid_fd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous imem with one-cycle latency; word i holds 0x1000_0000 + i.
   function automatic logic [31:0] mem_word(input logic [11:0] a);
      return 32'h1000_0000 | {20'd0, a};
   endfunction

   always @(posedge clock) imem_q <= mem_word(imem_addr);

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rdr;
      logic [31:0] rpc;
      logic [11:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        e_valid;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic rst, input logic stl, input logic rdr,
                               input logic [31:0] rpc, input logic [11:0] e_addr,
                               input logic [31:0] e_instr, input logic [31:0] e_pc,
                               input logic e_valid);
      vec_t v;
      v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
      v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc; v.e_valid = e_valid;
      return v;
   endfunction

   task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
      @(negedge clock);
      reset       = rst;
      stall       = stl;
      redirect    = rdr;
      redirect_pc = rpc;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [11:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_pc, input logic e_valid);
      tests_run++;
      if (imem_addr !== e_addr) begin
         tests_failed++;
         $display("FAIL %s imem_addr: got %h expected %h", name, imem_addr, e_addr);
      end
      tests_run++;
      if (instr_fd !== e_instr) begin
         tests_failed++;
         $display("FAIL %s instr_fd: got %h expected %h", name, instr_fd, e_instr);
      end
      tests_run++;
      if (pc_fd !== e_pc) begin
         tests_failed++;
         $display("FAIL %s pc_fd: got %h expected %h", name, pc_fd, e_pc);
      end
      tests_run++;
      if (valid_fd !== e_valid) begin
         tests_failed++;
         $display("FAIL %s valid_fd: got %b expected %b", name, valid_fd, e_valid);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      stall        = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = '0;

      // Reset, streaming, one-cycle stall after imem[5] issued, redirect to 0x40 with imem[7] in flight
      vecs[0]  = mk(1, 0, 0, 32'h0,  12'h000, 32'h0,         32'h0,  0);
      vecs[1]  = mk(0, 0, 0, 32'h0,  12'h001, 32'h0,         32'h0,  0);
      vecs[2]  = mk(0, 0, 0, 32'h0,  12'h002, 32'h1000_0000, 32'h1,  1);
      vecs[3]  = mk(0, 0, 0, 32'h0,  12'h003, 32'h1000_0001, 32'h2,  1);
      vecs[4]  = mk(0, 0, 0, 32'h0,  12'h004, 32'h1000_0002, 32'h3,  1);
      vecs[5]  = mk(0, 0, 0, 32'h0,  12'h005, 32'h1000_0003, 32'h4,  1);
      vecs[6]  = mk(0, 0, 0, 32'h0,  12'h006, 32'h1000_0004, 32'h5,  1);
      vecs[7]  = mk(0, 1, 0, 32'h0,  12'h006, 32'h1000_0004, 32'h5,  1);
      vecs[8]  = mk(0, 0, 0, 32'h0,  12'h007, 32'h1000_0005, 32'h6,  1);
      vecs[9]  = mk(0, 0, 0, 32'h0,  12'h008, 32'h1000_0006, 32'h7,  1);
      vecs[10] = mk(0, 0, 1, 32'h40, 12'h040, 32'h0,         32'h0,  0);
      vecs[11] = mk(0, 0, 0, 32'h0,  12'h041, 32'h0,         32'h0,  0);
      vecs[12] = mk(0, 0, 0, 32'h0,  12'h042, 32'h1000_0040, 32'h41, 1);
      vecs[13] = mk(0, 0, 0, 32'h0,  12'h043, 32'h1000_0041, 32'h42, 1);

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc);
         check($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid);
      end

      // Three-cycle stall: IF/ID frozen on imem[0x41], imem[0x42] parked in hold
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 32'h0);
         check($sformatf("stall3_%0d", i), 12'h043, 32'h1000_0041, 32'h42, 1);
      end
      step(0, 0, 0, 32'h0);
      check("stall3_rel0", 12'h044, 32'h1000_0042, 32'h43, 1);
      step(0, 0, 0, 32'h0);
      check("stall3_rel1", 12'h045, 32'h1000_0043, 32'h44, 1);

      // Fill the hold with imem[0x44], then redirect and stall together
      step(0, 1, 0, 32'h0);
      check("rs_fill", 12'h045, 32'h1000_0043, 32'h44, 1);
      step(0, 1, 1, 32'h80);
      check("rs_redir", 12'h080, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0);
      check("rs_bubble", 12'h081, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0);
      check("rs_target", 12'h082, 32'h1000_0080, 32'h81, 1);
      step(0, 0, 0, 32'h0);
      check("rs_next", 12'h083, 32'h1000_0081, 32'h82, 1);

      // PC wrap at 0xFFFFFFFF
      step(0, 0, 1, 32'hFFFF_FFFF);
      check("wrap_redir", 12'hFFF, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0);
      check("wrap_bubble", 12'h000, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0);
      check("wrap_top", 12'h001, 32'h1000_0FFF, 32'h0, 1);
      step(0, 0, 0, 32'h0);
      check("wrap_zero", 12'h002, 32'h1000_0000, 32'h1, 1);

      // Reset during a stall with the hold buffer full
      step(0, 1, 0, 32'h0);
      check("rst_stall", 12'h002, 32'h1000_0000, 32'h1, 1);
      step(1, 1, 0, 32'h0);
      check("rst_edge", 12'h000, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0);
      check("rst_bubble", 12'h001, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0);
      check("rst_first", 12'h002, 32'h1000_0000, 32'h1, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch of the pipelined processor.
- Drives the synchronous instruction memory and feeds the decode stage.
- Decode reads the latched instruction: opcode, source registers and the branch immediate, which it adds to PC+1.
- Handles hazard stalls and taken-branch/jump redirects from later stages.
- Includes a one-entry hold buffer so imem data returning during a stall is not lost.

Parameters:
- ADDR_W, 12: width of the imem address; driven from pc[ADDR_W-1:0].
- RESET_PC, 32'd0: word address fetched first after reset.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold the PC and the IF/ID latch this cycle.
- redirect  in  1  taken branch, jump or bex from a later stage; overrides stall.
- redirect_pc  in  32  target word address, valid when redirect=1.
- imem_addr  out  ADDR_W  imem address; equals pc[ADDR_W-1:0] combinationally.
- imem_q  in  32  imem data for the address presented in the previous cycle (1-cycle latency).
- instr_fd  out  32  IF/ID instruction; 32'b0 (NOP) when not valid.
- pc_fd  out  32  IF/ID PC+1 of instr_fd; 0 when not valid.
- valid_fd  out  1  IF/ID holds a real instruction.

Behaviour:
- Internal state:
  - pc (32): next fetch address.
  - req_valid and req_pc: a fetch was issued last cycle, so imem_q is meaningful this cycle.
  - hold_valid, hold_instr, hold_pc.
  - IF/ID registers.
- Reset, taking effect at the edge: pc=RESET_PC; req_valid=0; hold_valid=0; instr_fd=0; pc_fd=0; valid_fd=0.
- First cycle after reset: imem_addr=RESET_PC. The latch receives a bubble (req_valid=0).
- Candidate each cycle:
  - If hold_valid: {hold_instr, hold_pc}.
  - Else if req_valid: {imem_q, req_pc+1}.
  - Else: bubble (instr 0, pc 0, valid 0).
- Priority per edge: reset > redirect > stall > normal.
- Normal (no redirect, no stall):
  - IF/ID <= candidate.
  - hold_valid <= 0.
  - req_pc <= pc, req_valid <= 1, pc <= pc+1.
- Stall (no redirect):
  - IF/ID holds.
  - pc holds. imem_addr keeps showing pc, but that access is not counted.
  - req_valid <= 0.
  - If hold_valid=0 and req_valid=1: hold <= {imem_q, req_pc+1}, hold_valid <= 1. Otherwise hold is unchanged.
- Redirect (stall ignored):
  - pc <= redirect_pc.
  - req_valid <= 0: the in-flight wrong-path data is squashed.
  - hold_valid <= 0.
  - IF/ID <= bubble.
  - The target instruction reaches IF/ID two edges after the redirect edge.
- Stall release: the held instruction enters IF/ID on the first unstalled edge, immediately followed by the next sequential instruction. Nothing is lost or duplicated, and no extra bubble is inserted.
- Arithmetic: pc+1 and req_pc+1 wrap modulo 2^32. imem_addr simply truncates to ADDR_W bits, so PC 0xFFFFFFFF is followed by 0x0.
- Reset asserted mid-stall or mid-redirect returns all state to reset values at that edge. Any imem_q in flight is ignored.
- Steady state, no stalls: one instruction enters IF/ID per cycle. Latency from pc=A to instr_fd=imem[A] is 2 edges.

Test Plan:
- Reset, then run with imem[i]=0x1000_0000+i and no stall: instr_fd shows bubble, bubble, 0x10000000, 0x10000001, ... with pc_fd=1,2,... and valid_fd=1 from the third cycle.
- Stall on one cycle after imem[5] is issued: IF/ID holds imem[4]; imem[5] is captured in the hold buffer. After release, IF/ID shows imem[5] then imem[6], with no duplicate and no gap.
- Stall 3 consecutive cycles: instr_fd stays constant throughout; hold_valid is set once; release sequence is identical to the single-cycle case.
- Redirect to 0x40 while imem[7] is in flight: the next IF/ID is a bubble (valid_fd=0, instr_fd=0); the second edge after the redirect gives imem[0x40] with pc_fd=0x41; imem[7] never appears.
- Redirect and stall asserted together, with the hold buffer full: the redirect wins; the hold is discarded; instr_fd=imem[target] two edges later.
- pc=0xFFFFFFFF: imem_addr=0xFFF, and the next fetch is address 0; reset asserted during a stall gives valid_fd=0, pc=RESET_PC next cycle.
